// File: rtl/pico_pkg.sv
// pico_pkg: shared types and widths for the pico program sequencer.
//   state_e  - sequencer FSM states
//   INSTR_W  - instruction word width
//   LO_W     - width of the low-byte load field (instr[7:1])
//   RETIRE_W - width of the retired-instruction counter
package pico_pkg;

  localparam int unsigned INSTR_W  = 16;
  localparam int unsigned LO_W     = 7;
  localparam int unsigned RETIRE_W = 8;

  typedef enum logic [2:0] {
    StIdle,
    StLo,
    StHi,
    StExec,
    StDone
  } state_e;

endpackage

// File: rtl/pico_prog_ram.sv
// pico_prog_ram: DEPTH x INSTR_W flip-flop program store.
// One synchronous write port, one asynchronous read port, no reset
// (contents are undefined until written).
//   clk     - clock
//   wr_en   - write strobe
//   wr_addr - write slot
//   wr_data - word to store
//   rd_addr - read slot
//   rd_data - word at rd_addr (combinational)
module pico_prog_ram
  import pico_pkg::*;
#(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned AW    = 4
) (
  input  logic               clk,
  input  logic               wr_en,
  input  logic [AW-1:0]      wr_addr,
  input  logic [INSTR_W-1:0] wr_data,
  input  logic [AW-1:0]      rd_addr,
  output logic [INSTR_W-1:0] rd_data
);

  logic [INSTR_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/pico_prog_sequencer.sv
// pico_prog_sequencer: plays a stored program into the pico core's
// two-byte load protocol (LO, HI, EXEC per instruction) on a start trigger.
//   clk, rst_n        - clock, asynchronous active-low reset
//   wr_en/addr/data   - host write port into program RAM (idle/done only)
//   prog_len          - instruction count, sampled on accepted start
//   start, loop, abort- run control
//   ld_en, ld_lo, ld_hi - core load interface (ui_in[7], ui_in[6:0], uio_in)
//   busy, done        - run status
//   fetch_ptr         - slot currently delivered
//   retired           - EXEC cycles since last accepted start
//   wr_err, lsb_warn  - sticky error flags, cleared only by reset
module pico_prog_sequencer
  import pico_pkg::*;
#(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned AW    = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                wr_en,
  input  logic [AW-1:0]       wr_addr,
  input  logic [INSTR_W-1:0]  wr_data,
  input  logic [AW:0]         prog_len,
  input  logic                start,
  input  logic                loop,
  input  logic                abort,
  output logic                ld_en,
  output logic [LO_W-1:0]     ld_lo,
  output logic [7:0]          ld_hi,
  output logic                busy,
  output logic                done,
  output logic [AW-1:0]       fetch_ptr,
  output logic [RETIRE_W-1:0] retired,
  output logic                wr_err,
  output logic                lsb_warn
);

  state_e              state_q;
  logic [AW-1:0]       ptr_q;
  logic [AW:0]         len_q;
  logic                abort_q;
  logic                ld_en_q;
  logic [LO_W-1:0]     ld_lo_q;
  logic [7:0]          ld_hi_q;
  logic                busy_q;
  logic                done_q;
  logic [RETIRE_W-1:0] retired_q;
  logic                wr_err_q;
  logic                lsb_warn_q;

  logic               idle_or_done;
  logic               wr_ok;
  logic               start_ok;
  logic               last;
  logic               abort_seen;
  logic               enter_lo;
  logic [AW-1:0]      rd_addr;
  logic [INSTR_W-1:0] ram_rdata;
  logic [INSTR_W-1:0] rd_word;

  assign idle_or_done = (state_q == StIdle) || (state_q == StDone);
  assign wr_ok        = wr_en && idle_or_done;
  // Abort wins over a simultaneous start.
  assign start_ok     = start && !abort && idle_or_done;
  assign last         = ({1'b0, ptr_q} == (len_q - (AW+1)'(1)));
  assign abort_seen   = abort_q || abort;

  // Outputs are registered, so the word for the upcoming state is fetched
  // one cycle early: slot 0 on start, the next slot while in EXEC.
  always_comb begin
    rd_addr = ptr_q;
    unique case (state_q)
      StIdle, StDone: rd_addr = '0;
      StExec:         rd_addr = last ? '0 : ptr_q + AW'(1);
      default:        rd_addr = ptr_q;
    endcase
  end

  always_comb begin
    enter_lo = 1'b0;
    if (idle_or_done) begin
      enter_lo = start_ok && (prog_len != '0);
    end else if (state_q == StExec) begin
      enter_lo = !abort_seen && (!last || loop);
    end
  end

  pico_prog_ram #(
    .DEPTH(DEPTH),
    .AW   (AW)
  ) u_ram (
    .clk    (clk),
    .wr_en  (wr_ok),
    .wr_addr(wr_addr),
    .wr_data(wr_data),
    .rd_addr(rd_addr),
    .rd_data(ram_rdata)
  );

  // Bypass so a write landing in the same cycle as start reaches the first LO.
  assign rd_word = (wr_ok && (wr_addr == rd_addr)) ? wr_data : ram_rdata;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      ptr_q      <= '0;
      len_q      <= '0;
      abort_q    <= 1'b0;
      ld_en_q    <= 1'b0;
      ld_lo_q    <= '0;
      ld_hi_q    <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      retired_q  <= '0;
      wr_err_q   <= 1'b0;
      lsb_warn_q <= 1'b0;
    end else begin
      if (wr_en && !idle_or_done) begin
        wr_err_q <= 1'b1;
      end

      unique case (state_q)
        StIdle, StDone: begin
          if (start_ok) begin
            len_q     <= prog_len;
            ptr_q     <= '0;
            abort_q   <= 1'b0;
            retired_q <= '0;
            if (prog_len == '0) begin
              state_q <= StDone;
              done_q  <= 1'b1;
            end else begin
              state_q <= StLo;
              done_q  <= 1'b0;
              busy_q  <= 1'b1;
            end
          end
        end

        StLo: begin
          abort_q <= abort_seen;
          state_q <= StHi;
          ld_hi_q <= rd_word[15:8];
        end

        StHi: begin
          abort_q   <= abort_seen;
          state_q   <= StExec;
          ld_en_q   <= 1'b0;
          ld_lo_q   <= '0;
          ld_hi_q   <= '0;
          retired_q <= retired_q + RETIRE_W'(1);
        end

        StExec: begin
          abort_q <= 1'b0;
          if (abort_seen) begin
            state_q <= StIdle;
            busy_q  <= 1'b0;
          end else if (last && !loop) begin
            state_q <= StDone;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end else begin
            state_q <= StLo;
            ptr_q   <= last ? '0 : ptr_q + AW'(1);
          end
        end

        default: begin
          state_q <= StIdle;
          busy_q  <= 1'b0;
          ld_en_q <= 1'b0;
        end
      endcase

      // Common LO entry: present instr[7:1], hold the high byte at zero.
      if (enter_lo) begin
        ld_en_q <= 1'b1;
        ld_lo_q <= rd_word[7:1];
        ld_hi_q <= '0;
        if (rd_word[0]) begin
          lsb_warn_q <= 1'b1;
        end
      end
    end
  end

  assign ld_en     = ld_en_q;
  assign ld_lo     = ld_lo_q;
  assign ld_hi     = ld_hi_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign fetch_ptr = ptr_q;
  assign retired   = retired_q;
  assign wr_err    = wr_err_q;
  assign lsb_warn  = lsb_warn_q;

endmodule

// File: tb/tb_pico_prog_sequencer.sv
// Directed testbench for pico_prog_sequencer.
module tb_pico_prog_sequencer;

  logic        clk;
  logic        rst_n;
  logic        wr_en;
  logic [3:0]  wr_addr;
  logic [15:0] wr_data;
  logic [4:0]  prog_len;
  logic        start;
  logic        loop;
  logic        abort;
  logic        ld_en;
  logic [6:0]  ld_lo;
  logic [7:0]  ld_hi;
  logic        busy;
  logic        done;
  logic [3:0]  fetch_ptr;
  logic [7:0]  retired;
  logic        wr_err;
  logic        lsb_warn;

  logic [31:0] all_out;
  assign all_out = {ld_en, ld_lo, ld_hi, busy, done, fetch_ptr, retired, wr_err, lsb_warn};

  int n_vec = 0;
  int n_err = 0;

  pico_prog_sequencer #(
    .DEPTH(16),
    .AW   (4)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .prog_len (prog_len),
    .start    (start),
    .loop     (loop),
    .abort    (abort),
    .ld_en    (ld_en),
    .ld_lo    (ld_lo),
    .ld_hi    (ld_hi),
    .busy     (busy),
    .done     (done),
    .fetch_ptr(fetch_ptr),
    .retired  (retired),
    .wr_err   (wr_err),
    .lsb_warn (lsb_warn)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // Advance to 1 time unit after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write_slot(input logic [3:0] a, input logic [15:0] d);
    wr_en   = 1'b1;
    wr_addr = a;
    wr_data = d;
    tick();
    wr_en   = 1'b0;
  endtask

  // Expected LO/HI bytes for the three-word program 0015, 0535, 0001.
  logic [6:0] exp_lo [3] = '{7'h0A, 7'h1A, 7'h00};
  logic [7:0] exp_hi [3] = '{8'h00, 8'h05, 8'h00};

  initial begin
    rst_n    = 1'b0;
    wr_en    = 1'b0;
    wr_addr  = '0;
    wr_data  = '0;
    prog_len = '0;
    start    = 1'b0;
    loop     = 1'b0;
    abort    = 1'b0;
    repeat (3) tick();
    check("reset_outputs", all_out, 32'h0);
    rst_n = 1'b1;
    tick();
    check("idle_outputs", all_out, 32'h0);

    // Basic three-instruction run.
    write_slot(4'd0, 16'h0015);
    write_slot(4'd1, 16'h0535);
    write_slot(4'd2, 16'h0001);
    prog_len = 5'd3;
    start    = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check($sformatf("lo%0d_ld_en", i), 32'(ld_en), 32'd1);
      check($sformatf("lo%0d_ld_lo", i), 32'(ld_lo), 32'(exp_lo[i]));
      check($sformatf("lo%0d_ld_hi", i), 32'(ld_hi), 32'd0);
      check($sformatf("lo%0d_busy", i), 32'(busy), 32'd1);
      check($sformatf("lo%0d_ptr", i), 32'(fetch_ptr), 32'(i));
      tick();
      check($sformatf("hi%0d_ld_en", i), 32'(ld_en), 32'd1);
      check($sformatf("hi%0d_ld_lo", i), 32'(ld_lo), 32'(exp_lo[i]));
      check($sformatf("hi%0d_ld_hi", i), 32'(ld_hi), 32'(exp_hi[i]));
      tick();
      check($sformatf("ex%0d_ld_en", i), 32'(ld_en), 32'd0);
      check($sformatf("ex%0d_bytes", i), 32'({ld_lo, ld_hi}), 32'd0);
      check($sformatf("ex%0d_done", i), 32'(done), 32'd0);
      tick();
    end
    check("run_done", 32'(done), 32'd1);
    check("run_busy", 32'(busy), 32'd0);
    check("run_retired", 32'(retired), 32'd3);
    check("run_lsb_warn", 32'(lsb_warn), 32'd1);
    check("run_wr_err", 32'(wr_err), 32'd0);
    repeat (2) tick();
    check("done_held", 32'(done), 32'd1);

    // Loop run with busy-time write, busy-time start and an abort in HI.
    loop     = 1'b1;
    prog_len = 5'd2;
    start    = 1'b1;
    tick();                                     // c1 LO ptr0
    start = 1'b0;
    check("loop_c1_ptr", 32'(fetch_ptr), 32'd0);
    check("loop_c1_done", 32'(done), 32'd0);
    repeat (3) tick();                          // c4 LO ptr1
    check("loop_c4_ptr", 32'(fetch_ptr), 32'd1);
    tick();                                     // c5 HI
    wr_en   = 1'b1;
    wr_addr = 4'd1;
    wr_data = 16'hFFFF;
    start   = 1'b1;
    tick();                                     // c6 EXEC
    wr_en = 1'b0;
    start = 1'b0;
    check("busy_start_ignored", 32'(ld_en), 32'd0);
    check("wr_err_set", 32'(wr_err), 32'd1);
    tick();                                     // c7 LO ptr0 again
    check("loop_c7_ptr", 32'(fetch_ptr), 32'd0);
    check("loop_c7_ld_lo", 32'(ld_lo), 32'h0A);
    tick();                                     // c8 HI
    abort = 1'b1;
    tick();                                     // c9 EXEC still completes
    abort = 1'b0;
    check("abort_exec_runs", 32'(retired), 32'd3);
    check("abort_exec_busy", 32'(busy), 32'd1);
    tick();                                     // c10 IDLE
    check("abort_idle_busy", 32'(busy), 32'd0);
    check("abort_idle_done", 32'(done), 32'd0);
    check("abort_idle_ld_en", 32'(ld_en), 32'd0);
    check("abort_retired", 32'(retired), 32'd3);
    loop = 1'b0;

    // Start and abort together in IDLE: stay idle.
    prog_len = 5'd2;
    start    = 1'b1;
    abort    = 1'b1;
    tick();
    start = 1'b0;
    abort = 1'b0;
    check("start_abort_busy", 32'(busy), 32'd0);
    check("start_abort_ld_en", 32'(ld_en), 32'd0);
    tick();
    check("start_abort_idle", 32'(busy), 32'd0);

    // Zero-length program.
    prog_len = 5'd0;
    start    = 1'b1;
    tick();
    start = 1'b0;
    check("len0_done", 32'(done), 32'd1);
    check("len0_busy", 32'(busy), 32'd0);
    check("len0_ld_en", 32'(ld_en), 32'd0);
    tick();
    check("len0_busy2", 32'(busy), 32'd0);

    // Re-run two slots: slot 1 must still hold 0535.
    prog_len = 5'd2;
    start    = 1'b1;
    tick();
    start = 1'b0;
    check("rerun_start_clears_done", 32'(done), 32'd0);
    repeat (3) tick();
    check("ram_kept_lo", 32'(ld_lo), 32'h1A);
    tick();
    check("ram_kept_hi", 32'(ld_hi), 32'h05);
    repeat (2) tick();
    check("rerun_done", 32'(done), 32'd1);
    check("rerun_retired", 32'(retired), 32'd2);

    // Write in DONE keeps done; write with start is seen by the first LO.
    write_slot(4'd3, 16'h1234);
    check("write_in_done", 32'(done), 32'd1);
    prog_len = 5'd1;
    start    = 1'b1;
    wr_en    = 1'b1;
    wr_addr  = 4'd0;
    wr_data  = 16'h7BA4;
    tick();
    start = 1'b0;
    wr_en = 1'b0;
    check("bypass_ld_lo", 32'(ld_lo), 32'h52);
    tick();
    check("bypass_ld_hi", 32'(ld_hi), 32'h7B);
    repeat (2) tick();
    check("single_done", 32'(done), 32'd1);
    check("single_retired", 32'(retired), 32'd1);
    check("wr_err_sticky", 32'(wr_err), 32'd1);

    // Asynchronous reset in the middle of EXEC.
    prog_len = 5'd3;
    start    = 1'b1;
    tick();
    start = 1'b0;
    repeat (2) tick();                          // c3 EXEC
    check("pre_reset_retired", 32'(retired), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_reset_outputs", all_out, 32'h0);
    #3;
    rst_n = 1'b1;
    tick();
    check("after_reset_idle", all_out, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
